// File: rtl/prog_frame_monitor.sv
// prog_frame_monitor: SPI programming-frame length checker with LSB-first readback of the latched configuration.
// SCLK-domain flops count bits and shift readback; CS-rise flops classify each finished frame.
module prog_frame_monitor #(
    parameter int FRAME_BITS = 66
) (
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  SDI,
    input  logic [FRAME_BITS-1:0] prog_data,
    output logic                  SDO,
    output logic [6:0]            frame_len,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [7:0]            frame_cnt,
    output logic [3:0]            err_cnt
);
    logic [6:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] rb_shift_q, rb_shift_d;
    logic                  sdo_q, sdo_d;
    logic                  start_tgl_q, start_tgl_d;
    logic                  end_tgl_q, end_tgl_d;
    logic [6:0]            frame_len_q, frame_len_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [3:0]            err_cnt_q, err_cnt_d;
    logic                  new_frame, got_bits;
    logic                  sdi_unused;

    assign sdi_unused = SDI;

    // Toggle mismatch means a frame end has happened since the last SCLK-domain update.
    always_comb begin
        new_frame   = start_tgl_q != end_tgl_q;
        bit_cnt_d   = new_frame ? 7'd1 : (bit_cnt_q == 7'd127 ? bit_cnt_q : bit_cnt_q + 7'd1);
        rb_shift_d  = new_frame ? prog_data >> 1 : rb_shift_q >> 1;
        sdo_d       = new_frame ? prog_data[0] : rb_shift_q[0];
        start_tgl_d = end_tgl_q;
    end

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            bit_cnt_q   <= '0;
            rb_shift_q  <= '0;
            sdo_q       <= 1'b0;
            start_tgl_q <= 1'b0;
        end else if (!CS) begin
            bit_cnt_q   <= bit_cnt_d;
            rb_shift_q  <= rb_shift_d;
            sdo_q       <= sdo_d;
            start_tgl_q <= start_tgl_d;
        end
    end

    // SCLK is idle low at CS rise, so bit_cnt and start_tgl are stable here.
    always_comb begin
        got_bits    = start_tgl_q == end_tgl_q;
        frame_len_d = got_bits ? bit_cnt_q : 7'd0;
        frame_ok_d  = got_bits && (32'(frame_len_d) == FRAME_BITS);
        frame_err_d = !frame_ok_d;
        end_tgl_d   = got_bits ? !end_tgl_q : end_tgl_q;
        frame_cnt_d = frame_cnt_q + 8'd1;
        err_cnt_d   = (!frame_ok_d && err_cnt_q != 4'd15) ? err_cnt_q + 4'd1 : err_cnt_q;
    end

    always_ff @(posedge CS or negedge reset) begin
        if (!reset) begin
            end_tgl_q   <= 1'b0;
            frame_len_q <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            end_tgl_q   <= end_tgl_d;
            frame_len_q <= frame_len_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign SDO       = sdo_q;
    assign frame_len = frame_len_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule
